// File: rtl/demux_arr_pkg.sv
// Shared types and helpers for the demux array router.
package demux_arr_pkg;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_t;

  localparam int STAT_W = 16;

  // True when a select value addresses one of the n existing channels.
  function automatic logic sel_in_range(input logic [31:0] sel, input logic [31:0] n);
    return (sel < n);
  endfunction

endpackage

// File: rtl/demux_arr_router_if.sv
// Input stream plus per-channel output bundle of the demux array router.
interface demux_arr_router_if #(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 2
);
  localparam int SEL_W = (N_OUT <= 2) ? 1 : $clog2(N_OUT);

  logic                           in_valid;
  logic                           in_ready;
  logic [SEL_W-1:0]               in_sel;
  logic [DATA_W-1:0]              in_data;
  logic [N_OUT-1:0]               out_valid;
  logic [N_OUT-1:0]               out_ready;
  logic [N_OUT-1:0][DATA_W-1:0]   out_data;
  logic                           err_sel;

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, err_sel
  );

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, err_sel
  );
endinterface

// File: rtl/demux_arr_slot.sv
// One output channel: one-entry holding register with EMPTY/FULL state.
// Optional delivered-word counter under DEMUX_ARR_STATS_EN.
module demux_arr_slot
  import demux_arr_pkg::*;
#(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
`ifdef DEMUX_ARR_STATS_EN
  ,
  input  logic              stat_clr_i,
  output logic [STAT_W-1:0] stat_cnt_o
`endif
);

  ch_state_t         state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              drain_s;

  assign drain_s = (state_q == CH_FULL) && ready_i;

  // A load wins over a drain so a draining channel can refill in the same cycle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      state_d = CH_FULL;
      data_d  = data_i;
    end else if (drain_s) begin
      state_d = CH_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CH_EMPTY;
      data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == CH_FULL);
  assign data_o  = data_q;

`ifdef DEMUX_ARR_STATS_EN
  logic [STAT_W-1:0] cnt_q, cnt_d;

  // Clear has priority; the count saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (stat_clr_i) begin
      cnt_d = {STAT_W{1'b0}};
    end else if (drain_s && (cnt_q != {STAT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {STAT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stat_cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux_arr_router.sv
// Registered 1-to-N demultiplexer: one valid/ready stream fanned out to N_OUT slots.
// Optional per-channel delivery counters under DEMUX_ARR_STATS_EN.
module demux_arr_router
  import demux_arr_pkg::*;
#(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  demux_arr_router_if.slave             bus
`ifdef DEMUX_ARR_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [N_OUT-1:0][STAT_W-1:0]  stat_cnt
`endif
);

  localparam int SEL_W = (N_OUT <= 2) ? 1 : $clog2(N_OUT);

  logic [N_OUT-1:0]             slot_rdy_s;
  logic [N_OUT-1:0]             load_s;
  logic [N_OUT-1:0]             valid_s;
  logic [N_OUT-1:0][DATA_W-1:0] data_s;
  logic                         sel_ok_s;
  logic                         in_ready_s;
  logic                         accept_s;
  logic                         err_q, err_d;

  assign sel_ok_s   = sel_in_range(32'(bus.in_sel), 32'(N_OUT));
  assign slot_rdy_s = ~valid_s | bus.out_ready;

  // Out-of-range selects match no channel, leaving in_ready at 1 so they are consumed.
  always_comb begin
    in_ready_s = 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      in_ready_s = (bus.in_sel == SEL_W'(k)) ? slot_rdy_s[k] : in_ready_s;
    end
  end

  assign accept_s = bus.in_valid && in_ready_s;

  always_comb begin
    load_s = {N_OUT{1'b0}};
    for (int k = 0; k < N_OUT; k++) begin
      load_s[k] = accept_s && (bus.in_sel == SEL_W'(k));
    end
  end

  assign err_d = accept_s && !sel_ok_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    demux_arr_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load_s[g]),
      .data_i     (bus.in_data),
      .ready_i    (bus.out_ready[g]),
      .valid_o    (valid_s[g]),
      .data_o     (data_s[g])
`ifdef DEMUX_ARR_STATS_EN
      ,
      .stat_clr_i (stat_clr),
      .stat_cnt_o (stat_cnt[g])
`endif
    );
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = valid_s;
  assign bus.out_data  = data_s;
  assign bus.err_sel   = err_q;

endmodule

// File: tb/tb_demux_arr_router.sv
// Directed bench for demux_arr_router: 4-channel table plus 3-channel out-of-range case.
module tb_demux_arr_router;
  import demux_arr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  demux_arr_router_if #(.N_OUT(4), .DATA_W(2)) b4 ();
  demux_arr_router_if #(.N_OUT(3), .DATA_W(2)) b3 ();

`ifdef DEMUX_ARR_STATS_EN
  logic             stat_clr;
  logic [3:0][15:0] stat_cnt4;
  logic [2:0][15:0] stat_cnt3;
`endif

  demux_arr_router #(.N_OUT(4), .DATA_W(2)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
`ifdef DEMUX_ARR_STATS_EN
    ,
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt4)
`endif
  );

  demux_arr_router #(.N_OUT(3), .DATA_W(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
`ifdef DEMUX_ARR_STATS_EN
    ,
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt3)
`endif
  );

  typedef struct packed {
    logic       v;
    logic [1:0] sel;
    logic [1:0] data;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [3:0] exp_valid;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic apply4(input logic v, input logic [1:0] sel, input logic [1:0] d,
                        input logic [3:0] ordy);
    b4.in_valid  = v;
    b4.in_sel    = sel;
    b4.in_data   = d;
    b4.out_ready = ordy;
  endtask

  initial begin
    rst = 1'b1;
    apply4(1'b0, 2'd0, 2'd0, 4'd0);
    b3.in_valid = 1'b0; b3.in_sel = 2'd0; b3.in_data = 2'd0; b3.out_ready = 3'd0;
`ifdef DEMUX_ARR_STATS_EN
    stat_clr = 1'b0;
`endif

    //            v    sel   data   ordy     rdy   valid    data   err
    vecs[0]  = '{1'b1, 2'd2, 2'b10, 4'b0000, 1'b1, 4'b0100, 8'h20, 1'b0};
    vecs[1]  = '{1'b0, 2'd2, 2'b00, 4'b0000, 1'b0, 4'b0100, 8'h20, 1'b0};
    vecs[2]  = '{1'b0, 2'd1, 2'b00, 4'b0000, 1'b1, 4'b0100, 8'h20, 1'b0};
    vecs[3]  = '{1'b1, 2'd2, 2'b01, 4'b0000, 1'b0, 4'b0100, 8'h20, 1'b0};
    vecs[4]  = '{1'b0, 2'd1, 2'b00, 4'b0000, 1'b1, 4'b0100, 8'h20, 1'b0};
    vecs[5]  = '{1'b0, 2'd2, 2'b00, 4'b0000, 1'b0, 4'b0100, 8'h20, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 2'b00, 4'b0100, 1'b1, 4'b0000, 8'h20, 1'b0};
    vecs[7]  = '{1'b1, 2'd1, 2'b00, 4'b0010, 1'b1, 4'b0010, 8'h20, 1'b0};
    vecs[8]  = '{1'b1, 2'd1, 2'b01, 4'b0010, 1'b1, 4'b0010, 8'h24, 1'b0};
    vecs[9]  = '{1'b1, 2'd1, 2'b10, 4'b0010, 1'b1, 4'b0010, 8'h28, 1'b0};
    vecs[10] = '{1'b1, 2'd1, 2'b11, 4'b0010, 1'b1, 4'b0010, 8'h2C, 1'b0};
    vecs[11] = '{1'b0, 2'd1, 2'b00, 4'b0010, 1'b1, 4'b0000, 8'h2C, 1'b0};
    vecs[12] = '{1'b1, 2'd0, 2'b11, 4'b0000, 1'b1, 4'b0001, 8'h2F, 1'b0};
    vecs[13] = '{1'b1, 2'd3, 2'b01, 4'b0000, 1'b1, 4'b1001, 8'h6F, 1'b0};
    vecs[14] = '{1'b1, 2'd3, 2'b10, 4'b1001, 1'b1, 4'b1000, 8'hAF, 1'b0};
    vecs[15] = '{1'b1, 2'd3, 2'b11, 4'b0000, 1'b0, 4'b1000, 8'hAF, 1'b0};
    vecs[16] = '{1'b1, 2'd0, 2'b01, 4'b0000, 1'b1, 4'b1001, 8'hAD, 1'b0};
    vecs[17] = '{1'b1, 2'd1, 2'b00, 4'b0000, 1'b1, 4'b1011, 8'hA1, 1'b0};
    vecs[18] = '{1'b1, 2'd2, 2'b11, 4'b0000, 1'b1, 4'b1111, 8'hB1, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid4", 32'(b4.out_valid), 32'h0);
    chk("rst_data4",  32'(b4.out_data),  32'h0);
    chk("rst_err4",   32'(b4.err_sel),   32'h0);
    chk("rst_valid3", 32'(b3.out_valid), 32'h0);
    chk("rst_ready4", 32'(b4.in_ready),  32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven single-cycle vectors on the 4-channel instance.
    for (int i = 0; i < 19; i++) begin
      apply4(vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].ordy);
      #1;
      chk($sformatf("in_ready[%0d]", i), 32'(b4.in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("out_valid[%0d]", i), 32'(b4.out_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("out_data[%0d]", i),  32'(b4.out_data),  32'(vecs[i].exp_data));
      chk($sformatf("err_sel[%0d]", i),   32'(b4.err_sel),   32'(vecs[i].exp_err));
    end

    // Asynchronous reset mid-cycle with all channels full.
    apply4(1'b0, 2'd0, 2'd0, 4'b0000);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(b4.out_valid), 32'h0);
    chk("async_rst_data",  32'(b4.out_data),  32'h0);
    chk("async_rst_err",   32'(b4.err_sel),   32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 32'(b4.out_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    apply4(1'b1, 2'd0, 2'b10, 4'b0000);
    @(posedge clk);
    #1;
    chk("post_rst_accept_valid", 32'(b4.out_valid), 32'h1);
    chk("post_rst_accept_data",  32'(b4.out_data),  32'h02);
    apply4(1'b0, 2'd0, 2'd0, 4'b0001);
    @(posedge clk);
    #1;
    chk("post_rst_drain", 32'(b4.out_valid), 32'h0);
    apply4(1'b0, 2'd0, 2'd0, 4'b0000);

    // Out-of-range select on the 3-channel instance, two drops back to back.
    b3.in_valid = 1'b1; b3.in_sel = 2'b11; b3.in_data = 2'b01; b3.out_ready = 3'b000;
    #1;
    chk("oor_ready", 32'(b3.in_ready), 32'h1);
    chk("oor_err_before", 32'(b3.err_sel), 32'h0);
    @(posedge clk);
    #1;
    chk("oor_err1", 32'(b3.err_sel), 32'h1);
    chk("oor_valid1", 32'(b3.out_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("oor_err2", 32'(b3.err_sel), 32'h1);
    b3.in_sel = 2'd2; b3.in_data = 2'b11;
    @(posedge clk);
    #1;
    chk("oor_err_clear", 32'(b3.err_sel), 32'h0);
    chk("n3_valid", 32'(b3.out_valid), 32'h4);
    chk("n3_data",  32'(b3.out_data),  32'h30);
    b3.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("n3_hold", 32'(b3.out_data), 32'h30);

`ifdef DEMUX_ARR_STATS_EN
    // Three drains on channel 2, then clear concurrent with a fourth drain.
    for (int i = 0; i < 3; i++) begin
      apply4(1'b1, 2'd2, 2'(i), 4'b0000);
      @(posedge clk);
      #1;
      apply4(1'b0, 2'd0, 2'd0, 4'b0100);
      @(posedge clk);
      #1;
    end
    chk("stat_cnt2_3", 32'(stat_cnt4[2]), 32'd3);
    chk("stat_cnt0_1", 32'(stat_cnt4[0]), 32'd1);
    apply4(1'b1, 2'd2, 2'b11, 4'b0000);
    @(posedge clk);
    #1;
    stat_clr = 1'b1;
    apply4(1'b0, 2'd0, 2'd0, 4'b0100);
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    chk("stat_cnt2_clr", 32'(stat_cnt4[2]), 32'd0);
    chk("stat_cnt0_clr", 32'(stat_cnt4[0]), 32'd0);
    chk("stat_drain_valid", 32'(b4.out_valid), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/demux_arr_router.md
# demux_arr_router

Registered 1-to-N demultiplexer for the mux array path: accepts one valid/ready input stream carrying a channel select and a data word, and delivers each word to the selected output channel through a one-entry holding register per channel. It is the fan-out counterpart of the mux array: the mux array collects N sources onto one line, and this block distributes one line back to N sinks. It sits between the shared bus and the per-channel consumers. Out-of-range selects are consumed, dropped and flagged.

## Interface
- `N_OUT`, 4, number of output channels (2..16)
- `DATA_W`, 2, data word width
- `SEL_W`, `$clog2(N_OUT)` (minimum 1), select width
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `in_valid`  in  1  input word present
- `in_ready`  out  1  block can take the input word this cycle
- `in_sel`  in  `SEL_W`  target channel
- `in_data`  in  `DATA_W`  payload
- `out_valid`  out  `[N_OUT]`  per-channel word held
- `out_ready`  in  `[N_OUT]`  per-channel consumer ready
- `out_data`  out  `[N_OUT][DATA_W]`  per-channel held word
- `err_sel`  out  1  one-cycle pulse: out-of-range word dropped
- `stat_clr`  in  1  clear counters; present only with `DEMUX_ARR_STATS_EN`
- `stat_cnt`  out  `[N_OUT][16]`  per-channel delivered count; present only with `DEMUX_ARR_STATS_EN`

## Operation
- Per channel `k`: state EMPTY or FULL (`out_valid[k]` = FULL), data register `out_data[k]`.
- Input accept: `in_valid && in_ready`.
- `in_ready` for an in-range select = `!out_valid[in_sel] || out_ready[in_sel]`. It depends only on the selected channel.
- `in_ready` for an out-of-range select (`in_sel >= N_OUT`) = 1.
- In-range accept: the word loads into channel `in_sel`, which becomes FULL.
- Out-of-range accept: the word is discarded and `err_sel` pulses high the next cycle. No channel changes state.
- Channel drain: `out_valid[k] && out_ready[k]`. FULL goes to EMPTY unless the same-cycle accept targets `k`.
- Simultaneous drain and accept on the same channel: the channel stays FULL and loads the new word. This gives a throughput of 1 word/cycle per channel.
- Accepts and drains on different channels are independent and may occur in the same cycle.
- `out_data[k]` is stable while `out_valid[k]` is high and `out_ready[k]` is low.
- `out_data[k]` holds its last value when the channel is EMPTY.
- `in_data` and `in_sel` are ignored when `in_valid` is low.

## Timing
- Reset values:
  - `out_valid` all 0
  - `out_data` all 0
  - `err_sel` 0
  - `stat_cnt` all 0
- `in_ready` is combinational from `in_valid` is not used; it depends on `in_sel`, `out_valid` and `out_ready`.
- Latency: a word accepted at edge t drives `out_valid`/`out_data` from just after edge t. Consumers see it on the cycle after acceptance.
- `err_sel` is registered: high for exactly one cycle after each dropped word. Back-to-back drops give a continuous high level.
- Reset asserted mid-transfer: all held words are lost and channels go EMPTY immediately (asynchronous). No `err_sel` is produced. After deassertion, the first edge may accept.
- A `rst` deassertion edge does not count as an accept or drain.

## Configuration
- `DEMUX_ARR_STATS_EN` defined:
  - adds `stat_clr`, `stat_cnt`
  - `stat_cnt[k]` increments on each drain of channel `k` and saturates at 16'hFFFF
  - `stat_clr` zeroes all counters synchronously and takes priority over an increment in the same cycle
- `DEMUX_ARR_STATS_EN` undefined: ports and counters are absent, and datapath behaviour is identical.

## Structure
- Package `demux_arr_pkg`:
  - `typedef enum logic {CH_EMPTY, CH_FULL} ch_state_t`
  - `localparam STAT_W = 16`
  - a helper function `sel_in_range(sel, n)`
- Sub-module `demux_arr_slot`: one channel's holding register and state (load, drain, optional counter). It is instantiated `N_OUT` times in a generate loop.
- The top holds select decode, `in_ready` logic and `err_sel`.

## Test plan
- Reset, then `in_sel=2`, `in_data=2'b10`, one accept, `out_ready=0` → `out_valid=4'b0100`, `out_data[2]=2'b10`. The data holds for 5 cycles, and `in_ready=0` for `sel=2` while `in_ready=1` for `sel=1`.
- Streaming to channel 1 with `out_ready[1]=1`, data 00, 01, 10, 11 on 4 consecutive cycles → `in_ready` stays 1. `out_data[1]` shows the same sequence one cycle later, with no bubbles.
- `N_OUT=3`, `in_sel=2'b11`, `in_data=2'b01`, `in_valid=1` → accepted (`in_ready=1`), `err_sel=1` for one cycle, `out_valid` unchanged at 0.
- Channels 0 and 3 FULL, drain channel 0 while accepting into channel 3 with `out_ready[3]=1` → channel 0 EMPTY, channel 3 FULL with the new word.
- Assert `rst` asynchronously mid-cycle while channels 0–3 are FULL → `out_valid=0` immediately, before the next edge.
- With `DEMUX_ARR_STATS_EN`: 3 drains on channel 2, then `stat_clr` on the same cycle as a 4th drain → `stat_cnt[2]` reads 3, then 0.
